stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Operand stack and stack-pointer datapath that executes the stack-side control fields produced by the instruction decoder: StackUpdateMode and StackWriteSrc.
- Sits beside the ALU in the single-cycle stack CPU.
- Supplies the top two entries combinationally as ALU/branch/dmem operands.
- Commits one write plus one SP update per enabled clock edge.
- Detects overflow and underflow, and suppresses illegal commits.

Parameters:
- DATA_W, 32, width of each stack entry and of every write source.
- DEPTH, 16, number of stack entries (power of two, at least 4).
- ADDR_W, $clog2(DEPTH), entry index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- en  input  1  commit strobe; instruction retires this cycle
- StackUpdateMode  input  2  00: sp, 01: sp+1, 10: sp-2, 11: sp-1
- StackWriteSrc  input  2  00: no write, 01: ALUresult, 10: dmem_read, 11: PC_temp
- alu_result  input  DATA_W  ALU result write source
- dmem_rdata  input  DATA_W  data-memory read write source
- pc_temp  input  DATA_W  PC+4 write source
- top  output  DATA_W  mem[sp-1]; 0 when sp==0
- second  output  DATA_W  mem[sp-2]; 0 when sp<2
- sp  output  ADDR_W+1  number of valid entries, 0..DEPTH
- empty  output  1  sp==0
- full  output  1  sp==DEPTH
- overflow  output  1  sticky: illegal push attempted
- underflow  output  1  sticky: illegal pop or read attempted

Behaviour:
- Reset, asynchronous and immediate, also mid-operation:
  - sp=0; all entries=0; overflow=0; underflow=0.
  - Hence top=0, second=0, empty=1, full=0.
- top, second, empty and full are combinational from registered state. There is no read latency.
- sp_next by mode: 00 → sp; 01 → sp+1; 10 → sp-2; 11 → sp-1.
- The write target is always the new top, mem[sp_next-1]:
  - mode 01 writes mem[sp] (push).
  - mode 00 writes mem[sp-1] (unary replace-top).
  - mode 11 writes mem[sp-2] (binary result replaces the two operands).
  - mode 10 with a write is illegal; it is treated as underflow.
- Write data by src: 01 alu_result, 10 dmem_rdata, 11 pc_temp. With src 00, no entry changes.
- Legality check, evaluated only when en=1:
  - Overflow when mode 01 and sp==DEPTH.
  - Underflow in any of these cases:
    - mode 11 and sp<1;
    - mode 10 and sp<2;
    - mode 10 and src!=00;
    - mode 00 and src!=00 and sp<1;
    - mode 11 and src!=00 and sp<2.
- Legal commit: sp<=sp_next and the selected entry is written, both on the same edge.
- Illegal commit: sp and all entries are held. The matching sticky flag goes to 1 on that edge and stays set until reset.
  - Overflow and underflow cannot both fire in one cycle.
  - Later legal commits still execute while a flag is set; the flag is advisory to the core.
- en=0: no state change, no flag change, regardless of the control inputs.
- Mode 00 with src 00 is a legal no-op at any sp, including 0.
- Wrap-around never occurs: sp saturates by suppression, never modulo.
- Entries at index ≥ sp keep stale data. They are never visible on top/second because of the zero masking.
- Push then immediate read: the value appears on top the cycle after the commit edge. There is no bypass.

Decomposition:
- Shared package stack_pkg holds:
  - localparams for the StackUpdateMode encodings SP_HOLD=2'b00, SP_INC=2'b01, SP_DEC2=2'b10, SP_DEC1=2'b11;
  - localparams for the StackWriteSrc encodings WR_NONE=2'b00, WR_ALU=2'b01, WR_DMEM=2'b10, WR_PC=2'b11.
  - The decoder and this block both import it.
- One natural sub-module: stack_regfile.
  - Contents: DEPTH×DATA_W storage with async reset, one write port and two combinational read ports.
  - The parent holds the sp arithmetic, legality check and sticky flags.

Test Plan:
1. Reset then check idle state: sp=0, empty=1, top=0, second=0, flags=0. Then en=1, mode 00, src 00 → nothing changes.
2. Push 5 then 7 (mode 01, src 01, alu_result 5 then 7). Then binary op (mode 11, src 01, alu_result 12) → sp goes 1, 2, 1; top=12; second=0.
3. With sp=1: mode 11 src 11 pc_temp=0x40 → underflow=1, sp stays 1, top unchanged. Then a legal push of dmem_rdata=0xAB → sp=2, top=0xAB, underflow still 1.
4. Push DEPTH values 1..16 → full=1, top=16. Push 99 → overflow=1, sp=16, top=16. Mode 10 src 00 → sp=14, top=14.
5. en=0 with mode 01 src 01 held for 3 cycles → sp, entries and flags unchanged.
6. Assert reset asynchronously mid-cycle with sp=3 and overflow=1 → outputs return to reset values before the next clk edge; the first push afterwards lands at index 0.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared stack control-field encodings for decoder and stack datapath
package stack_pkg;
    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC2 = 2'b10;
    localparam logic [1:0] SP_DEC1 = 2'b11;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_ALU  = 2'b01;
    localparam logic [1:0] WR_DMEM = 2'b10;
    localparam logic [1:0] WR_PC   = 2'b11;
endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - operand stack storage, one write port and two combinational read ports
module stack_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack with sp arithmetic, legality check and sticky overflow/underflow flags
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        StackUpdateMode,
    input  logic [1:0]        StackWriteSrc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] pc_temp,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] second,
    output logic [ADDR_W:0]   sp,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0]   SP_ZERO = '0;
    localparam logic [ADDR_W:0]   SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   SP_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   SP_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_TWO = ADDR_W'(2);

    logic [ADDR_W-1:0] sp_lo, idx_top, idx_second, waddr;
    logic [ADDR_W:0]   sp_next;
    logic [DATA_W-1:0] wdata, rd_top, rd_second;
    logic              has_wr, ovf_cond, udf_cond, legal, we;

    // Index arithmetic is modulo DEPTH; out-of-range cases are masked or suppressed.
    assign sp_lo      = sp[ADDR_W-1:0];
    assign idx_top    = sp_lo - IDX_ONE;
    assign idx_second = sp_lo - IDX_TWO;

    assign empty  = (sp == SP_ZERO);
    assign full   = (sp == SP_MAX);
    assign top    = (sp < SP_ONE) ? '0 : rd_top;
    assign second = (sp < SP_TWO) ? '0 : rd_second;

    assign has_wr = (StackWriteSrc != WR_NONE);

    always_comb begin
        sp_next = sp;
        waddr   = idx_top;
        case (StackUpdateMode)
            SP_HOLD: begin sp_next = sp;          waddr = idx_top;    end
            SP_INC:  begin sp_next = sp + SP_ONE; waddr = sp_lo;      end
            SP_DEC2: begin sp_next = sp - SP_TWO; waddr = idx_second; end
            default: begin sp_next = sp - SP_ONE; waddr = idx_second; end
        endcase
    end

    always_comb begin
        wdata = '0;
        case (StackWriteSrc)
            WR_ALU:  wdata = alu_result;
            WR_DMEM: wdata = dmem_rdata;
            WR_PC:   wdata = pc_temp;
            default: wdata = '0;
        endcase
    end

    // Conditions are keyed on mode, so overflow and underflow are mutually exclusive.
    assign ovf_cond = en && (StackUpdateMode == SP_INC) && (sp == SP_MAX);
    assign udf_cond = en && (((StackUpdateMode == SP_DEC1) && (sp < SP_ONE)) ||
                             ((StackUpdateMode == SP_DEC2) && (sp < SP_TWO)) ||
                             ((StackUpdateMode == SP_DEC2) && has_wr) ||
                             ((StackUpdateMode == SP_HOLD) && has_wr && (sp < SP_ONE)) ||
                             ((StackUpdateMode == SP_DEC1) && has_wr && (sp < SP_TWO)));
    assign legal = en && !ovf_cond && !udf_cond;
    assign we    = legal && has_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (legal)    sp        <= sp_next;
            if (ovf_cond) overflow  <= 1'b1;
            if (udf_cond) underflow <= 1'b1;
        end
    end

    stack_regfile #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr_a(idx_top),
        .rdata_a(rd_top),
        .raddr_b(idx_second),
        .rdata_b(rd_second)
    );
endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed self-checking bench for stack_unit
module tb_stack_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [1:0]        src = 2'b00;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic [DATA_W-1:0] pc_temp = '0;
    logic [DATA_W-1:0] top, second;
    logic [ADDR_W:0]   sp;
    logic              empty, full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .StackUpdateMode(mode), .StackWriteSrc(src),
        .alu_result(alu_result), .dmem_rdata(dmem_rdata), .pc_temp(pc_temp),
        .top(top), .second(second), .sp(sp), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic commit(input logic [1:0] m, input logic [1:0] s, input logic [DATA_W-1:0] d);
        mode = m; src = s; alu_result = d; dmem_rdata = d; pc_temp = d; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sp !== 5'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", sp); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
        checks++; if (top !== 32'd0 || second !== 32'd0) begin errors++; $display("FAIL reset_top_second got %h %h exp 0 0", top, second); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
        commit(2'b00, 2'b00, 32'h1234);
        checks++; if (sp !== 5'd0 || top !== 32'd0 || underflow !== 1'b0 || overflow !== 1'b0) begin errors++;
            $display("FAIL nop_at_empty got sp=%0d top=%h uf=%b of=%b exp 0 0 0 0", sp, top, underflow, overflow); end
    endtask

    task automatic test_push_binop();
        commit(2'b01, 2'b01, 32'd5);
        checks++; if (sp !== 5'd1 || top !== 32'd5 || second !== 32'd0) begin errors++;
            $display("FAIL push5 got sp=%0d top=%0d second=%0d exp 1 5 0", sp, top, second); end
        commit(2'b01, 2'b01, 32'd7);
        checks++; if (sp !== 5'd2 || top !== 32'd7 || second !== 32'd5) begin errors++;
            $display("FAIL push7 got sp=%0d top=%0d second=%0d exp 2 7 5", sp, top, second); end
        commit(2'b11, 2'b01, 32'd12);
        checks++; if (sp !== 5'd1 || top !== 32'd12 || second !== 32'd0) begin errors++;
            $display("FAIL binop got sp=%0d top=%0d second=%0d exp 1 12 0", sp, top, second); end
    endtask

    task automatic test_underflow();
        commit(2'b11, 2'b11, 32'h40);
        checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin errors++;
            $display("FAIL binop_sp1_flags got uf=%b of=%b exp 1 0", underflow, overflow); end
        checks++; if (sp !== 5'd1 || top !== 32'd12) begin errors++;
            $display("FAIL binop_sp1_hold got sp=%0d top=%h exp 1 c", sp, top); end
        commit(2'b01, 2'b10, 32'hAB);
        checks++; if (sp !== 5'd2 || top !== 32'hAB || second !== 32'd12 || underflow !== 1'b1) begin errors++;
            $display("FAIL push_after_uf got sp=%0d top=%h second=%h uf=%b exp 2 ab c 1", sp, top, second, underflow); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) commit(2'b01, 2'b01, 32'(i));
        checks++; if (sp !== 5'd16 || full !== 1'b1 || empty !== 1'b0 || top !== 32'd16 || second !== 32'd15) begin errors++;
            $display("FAIL fill got sp=%0d full=%b top=%0d second=%0d exp 16 1 16 15", sp, full, top, second); end
        commit(2'b01, 2'b01, 32'd99);
        checks++; if (overflow !== 1'b1 || underflow !== 1'b0 || sp !== 5'd16 || top !== 32'd16) begin errors++;
            $display("FAIL push_full got of=%b uf=%b sp=%0d top=%0d exp 1 0 16 16", overflow, underflow, sp, top); end
        commit(2'b10, 2'b00, 32'd0);
        checks++; if (sp !== 5'd14 || top !== 32'd14 || second !== 32'd13 || full !== 1'b0) begin errors++;
            $display("FAIL pop2 got sp=%0d top=%0d second=%0d full=%b exp 14 14 13 0", sp, top, second, full); end
        commit(2'b10, 2'b01, 32'd55);
        checks++; if (underflow !== 1'b1 || sp !== 5'd14 || top !== 32'd14) begin errors++;
            $display("FAIL pop2_with_write got uf=%b sp=%0d top=%0d exp 1 14 14", underflow, sp, top); end
        commit(2'b00, 2'b01, 32'd77);
        checks++; if (sp !== 5'd14 || top !== 32'd77 || second !== 32'd13) begin errors++;
            $display("FAIL replace_top got sp=%0d top=%0d second=%0d exp 14 77 13", sp, top, second); end
    endtask

    task automatic test_en_low();
        mode = 2'b01; src = 2'b01; alu_result = 32'd123; en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sp !== 5'd14 || top !== 32'd77 || second !== 32'd13 || overflow !== 1'b1 || underflow !== 1'b1) begin errors++;
            $display("FAIL en_low got sp=%0d top=%0d second=%0d of=%b uf=%b exp 14 77 13 1 1", sp, top, second, overflow, underflow); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) commit(2'b10, 2'b00, 32'd0);
        commit(2'b11, 2'b00, 32'd0);
        checks++; if (sp !== 5'd3 || top !== 32'd3 || overflow !== 1'b1) begin errors++;
            $display("FAIL pre_async got sp=%0d top=%0d of=%b exp 3 3 1", sp, top, overflow); end
        #2 reset = 1'b1;
        #1;
        checks++; if (sp !== 5'd0 || top !== 32'd0 || second !== 32'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++;
            $display("FAIL async_reset got sp=%0d top=%h second=%h empty=%b of=%b uf=%b exp 0 0 0 1 0 0", sp, top, second, empty, overflow, underflow); end
        #1 reset = 1'b0;
        commit(2'b01, 2'b01, 32'h55);
        checks++; if (sp !== 5'd1 || top !== 32'h55 || second !== 32'd0) begin errors++;
            $display("FAIL push_after_reset got sp=%0d top=%h second=%h exp 1 55 0", sp, top, second); end
        commit(2'b11, 2'b00, 32'd0);
        commit(2'b11, 2'b00, 32'd0);
        checks++; if (underflow !== 1'b1 || sp !== 5'd0 || top !== 32'd0) begin errors++;
            $display("FAIL pop_empty got uf=%b sp=%0d top=%h exp 1 0 0", underflow, sp, top); end
    endtask

    initial begin
        test_reset();
        test_push_binop();
        test_underflow();
        test_full();
        test_en_low();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
